// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared video timing types, mode constants and helpers
package vga_timing_pkg;

   typedef enum logic [1:0] {
      REGION_ACTIVE,
      REGION_FP,
      REGION_SYNC,
      REGION_BP
   } region_e;

   typedef struct packed {
      int active;
      int fp;
      int sync;
      int bp;
   } axis_timing_t;

   localparam axis_timing_t VGA640X480_H = '{active: 640, fp: 16, sync: 96, bp: 48};
   localparam axis_timing_t VGA640X480_V = '{active: 480, fp: 10, sync: 2, bp: 33};

   // Half-resolution raster, doubled to 640x480 by the downstream output stage
   localparam axis_timing_t VGA320X240_H = '{active: 320, fp: 8, sync: 48, bp: 24};
   localparam axis_timing_t VGA320X240_V = '{active: 240, fp: 5, sync: 1, bp: 17};

   function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
      return active + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with wrap and region decode
module vga_axis_counter
   import vga_timing_pkg::*;
#(
   parameter int ACTIVE = 640,
   parameter int FP     = 16,
   parameter int SYNC   = 96,
   parameter int BP     = 48,
   parameter int CW     = 12
) (
   input  logic          Clk,
   input  logic          Reset_n,
   input  logic          inc,
   input  logic          clr,
   output logic [CW-1:0] count,
   output logic          wrap,
   output logic          blank,
   output logic          in_sync
);

   localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
   localparam logic [CW-1:0] LAST       = CW'(TOTAL - 1);
   localparam logic [CW-1:0] FP_START   = CW'(ACTIVE);
   localparam logic [CW-1:0] SYNC_START = CW'(ACTIVE + FP);
   localparam logic [CW-1:0] BP_START   = CW'(ACTIVE + FP + SYNC);

   if (TOTAL >= (1 << CW)) begin : g_total_too_wide
      $error("vga_axis_counter: axis total does not fit in CW bits");
   end

   region_e region;

   assign wrap = inc & (count == LAST);

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         count <= '0;
      end else if (clr) begin
         count <= '0;
      end else if (inc) begin
         count <= wrap ? '0 : count + 1'b1;
      end
   end

   always_comb begin
      region = REGION_BP;
      if (count < FP_START) begin
         region = REGION_ACTIVE;
      end else if (count < SYNC_START) begin
         region = REGION_FP;
      end else if (count < BP_START) begin
         region = REGION_SYNC;
      end
   end

   assign blank   = (region != REGION_ACTIVE);
   assign in_sync = (region == REGION_SYNC);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised video timing generator with registered, coherent outputs
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int H_ACTIVE = VGA640X480_H.active,
   parameter int H_FP     = VGA640X480_H.fp,
   parameter int H_SYNC   = VGA640X480_H.sync,
   parameter int H_BP     = VGA640X480_H.bp,
   parameter int V_ACTIVE = VGA640X480_V.active,
   parameter int V_FP     = VGA640X480_V.fp,
   parameter int V_SYNC   = VGA640X480_V.sync,
   parameter int V_BP     = VGA640X480_V.bp,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int CW       = 12,
   parameter int FCW      = 8
) (
   input  logic           Clk,
   input  logic           Reset_n,
   input  logic           ce,
   input  logic           run,
   output logic           hsync,
   output logic           vsync,
   output logic           hblank,
   output logic           vblank,
   output logic           de,
   output logic [CW-1:0]  counter_x,
   output logic [CW-1:0]  counter_y,
   output logic           sol,
   output logic           sof,
   output logic [FCW-1:0] frame_cnt
);

   logic          advance, clr;
   logic [CW-1:0] hx, vy;
   logic          h_wrap, h_blank, h_in_sync;
   logic          v_wrap, v_blank, v_in_sync;
   logic          at_origin;

   assign advance = ce & run;
   assign clr     = ce & ~run;

   vga_axis_counter #(
      .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(CW)
   ) u_h_axis (
      .Clk(Clk), .Reset_n(Reset_n), .inc(advance), .clr(clr),
      .count(hx), .wrap(h_wrap), .blank(h_blank), .in_sync(h_in_sync)
   );

   vga_axis_counter #(
      .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(CW)
   ) u_v_axis (
      .Clk(Clk), .Reset_n(Reset_n), .inc(h_wrap), .clr(clr),
      .count(vy), .wrap(v_wrap), .blank(v_blank), .in_sync(v_in_sync)
   );

   // Tracks (hx,vy)==(0,0): counters land on the origin after a frame wrap or a run=0 tick
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         at_origin <= 1'b1;
      end else if (ce) begin
         at_origin <= ~run | v_wrap;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         hsync     <= ~HS_POL;
         vsync     <= ~VS_POL;
         hblank    <= 1'b1;
         vblank    <= 1'b1;
         de        <= 1'b0;
         counter_x <= '0;
         counter_y <= '0;
         sol       <= 1'b0;
         sof       <= 1'b0;
         frame_cnt <= '0;
      end else if (ce) begin
         hsync     <= h_in_sync ? HS_POL : ~HS_POL;
         // vsync only samples on the hsync leading edge so both edges line up
         if (h_in_sync && (hsync != HS_POL)) begin
            vsync <= v_in_sync ? VS_POL : ~VS_POL;
         end
         hblank    <= h_blank;
         vblank    <= v_blank;
         de        <= ~h_blank & ~v_blank;
         counter_x <= hx;
         counter_y <= vy;
         sol       <= (hx == '0);
         sof       <= at_origin;
         if (at_origin && run) begin
            frame_cnt <= frame_cnt + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed bench for vga_timing_gen in small mode and default 640x480 mode
`timescale 1ns/1ps
module tb_vga_timing_gen;

   logic        Clk = 1'b0;
   logic        Reset_n, ce, run;
   logic        s_hsync, s_vsync, s_hblank, s_vblank, s_de, s_sol, s_sof;
   logic [11:0] s_cx, s_cy;
   logic [7:0]  s_fc;
   logic        d_hsync, d_vsync, d_hblank, d_vblank, d_de, d_sol, d_sof;
   logic [11:0] d_cx, d_cy;
   logic [7:0]  d_fc;

   int n_cmp = 0;
   int n_bad = 0;
   int cur_idx = 0;

   always #5 Clk = ~Clk;

   vga_timing_gen #(
      .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
      .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .VS_POL(1'b0), .CW(12), .FCW(8)
   ) u_small (
      .Clk(Clk), .Reset_n(Reset_n), .ce(ce), .run(run),
      .hsync(s_hsync), .vsync(s_vsync), .hblank(s_hblank), .vblank(s_vblank), .de(s_de),
      .counter_x(s_cx), .counter_y(s_cy), .sol(s_sol), .sof(s_sof), .frame_cnt(s_fc)
   );

   vga_timing_gen u_dflt (
      .Clk(Clk), .Reset_n(Reset_n), .ce(ce), .run(run),
      .hsync(d_hsync), .vsync(d_vsync), .hblank(d_hblank), .vblank(d_vblank), .de(d_de),
      .counter_x(d_cx), .counter_y(d_cy), .sol(d_sol), .sof(d_sof), .frame_cnt(d_fc)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s idx=%0d observed=%0d expected=%0d", tag, cur_idx, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   // Small mode: H 8/2/2/2 (total 14), V 4/1/1/1 (total 7), both syncs active-low
   task automatic check_small(input int idx, input int fcb);
      int x, y;
      logic vs_on;
      x = idx % 14;
      y = (idx / 14) % 7;
      vs_on = (y == 5 && x >= 10) || (y == 6 && x < 10);
      cur_idx = idx;
      chk("s_counter_x", s_cx, x);
      chk("s_counter_y", s_cy, y);
      chk("s_hsync", s_hsync, (x >= 10 && x <= 11) ? 0 : 1);
      chk("s_vsync", s_vsync, vs_on ? 0 : 1);
      chk("s_hblank", s_hblank, (x >= 8) ? 1 : 0);
      chk("s_vblank", s_vblank, (y >= 4) ? 1 : 0);
      chk("s_de", s_de, (x < 8 && y < 4) ? 1 : 0);
      chk("s_sol", s_sol, (x == 0) ? 1 : 0);
      chk("s_sof", s_sof, (x == 0 && y == 0) ? 1 : 0);
      chk("s_frame_cnt", s_fc, (fcb + idx / 98 + 1) % 256);
   endtask

   task automatic check_dflt(input int idx, input int fcb);
      int x, y;
      logic vs_on;
      x = idx % 800;
      y = (idx / 800) % 525;
      vs_on = (y == 490 && x >= 656) || (y == 491) || (y == 492 && x < 656);
      cur_idx = idx;
      chk("d_counter_x", d_cx, x);
      chk("d_counter_y", d_cy, y);
      chk("d_hsync", d_hsync, (x >= 656 && x <= 751) ? 1 : 0);
      chk("d_vsync", d_vsync, vs_on ? 1 : 0);
      chk("d_de", d_de, (x < 640 && y < 480) ? 1 : 0);
      chk("d_sol", d_sol, (x == 0) ? 1 : 0);
      chk("d_sof", d_sof, (x == 0 && y == 0) ? 1 : 0);
      chk("d_frame_cnt", d_fc, (fcb + idx / 420000 + 1) % 256);
   endtask

   initial begin
      int m, fcb, fc_hold, de_cnt, d_hs_cnt, sol_clks;
      logic [7:0] fc_before, fc_after;

      Reset_n = 1'b0;
      ce      = 1'b0;
      run     = 1'b0;
      repeat (3) @(posedge Clk);
      #1;
      chk("rst_s_hsync", s_hsync, 1);
      chk("rst_s_vsync", s_vsync, 1);
      chk("rst_s_hblank", s_hblank, 1);
      chk("rst_s_vblank", s_vblank, 1);
      chk("rst_s_de", s_de, 0);
      chk("rst_s_sol", s_sol, 0);
      chk("rst_s_sof", s_sof, 0);
      chk("rst_s_cx", s_cx, 0);
      chk("rst_s_cy", s_cy, 0);
      chk("rst_s_fc", s_fc, 0);
      chk("rst_d_hsync", d_hsync, 0);
      chk("rst_d_vsync", d_vsync, 0);
      chk("rst_d_hblank", d_hblank, 1);
      chk("rst_d_vblank", d_vblank, 1);

      // Free run: ~8 small frames and the first default line plus a bit of the second
      Reset_n = 1'b1;
      ce      = 1'b1;
      run     = 1'b1;
      de_cnt   = 0;
      d_hs_cnt = 0;
      for (int i = 0; i < 810; i++) begin
         tick();
         check_small(i, 0);
         check_dflt(i, 0);
         if (i < 98 && s_de) de_cnt++;
         if (i < 800 && d_hsync) d_hs_cnt++;
      end
      chk("s_de_per_frame", de_cnt, 32);
      chk("d_hsync_width", d_hs_cnt, 96);
      m = 810;

      // ce toggling: outputs hold on ce=0 clocks, sol stretches to two clocks
      sol_clks = 0;
      for (int i = 0; i < 56; i++) begin
         ce = (i % 2 == 0);
         tick();
         if (ce) m++;
         check_small(m - 1, 0);
         if (s_sol) sol_clks++;
      end
      chk("s_sol_stretch", sol_clks, 4);
      ce = 1'b1;

      // Drop run at small (x=5,y=2) for 10 ce ticks
      while ((m % 98) != 33) begin
         tick();
         check_small(m, 0);
         m++;
      end
      run = 1'b0;
      tick();
      check_small(m, 0);
      fc_hold = (m / 98 + 1) % 256;
      for (int i = 0; i < 9; i++) begin
         tick();
         cur_idx = i;
         chk("hold_cx", s_cx, 0);
         chk("hold_cy", s_cy, 0);
         chk("hold_sof", s_sof, 1);
         chk("hold_sol", s_sol, 1);
         chk("hold_de", s_de, 1);
         chk("hold_hsync", s_hsync, 1);
         chk("hold_vsync", s_vsync, 1);
         chk("hold_fc", s_fc, fc_hold);
      end
      run = 1'b1;
      fcb = fc_hold;
      for (m = 0; m < 14; m++) begin
         tick();
         check_small(m, fcb);
         check_dflt(m, 1);
      end

      // Long run through the 255 -> 0 frame counter wrap
      fc_before = '0;
      fc_after  = '1;
      for (; m < (256 - fcb) * 98 + 10; m++) begin
         tick();
         check_small(m, fcb);
         if (m == (255 - fcb) * 98 - 1) fc_before = s_fc;
         if (m == (255 - fcb) * 98) fc_after = s_fc;
      end
      chk("fc_before_wrap", fc_before, 255);
      chk("fc_after_wrap", fc_after, 0);

      // Asynchronous reset mid-line at default x=400
      while ((m % 800) != 400) begin
         tick();
         check_small(m, fcb);
         m++;
      end
      tick();
      check_small(m, fcb);
      check_dflt(m, 1);
      #2;
      Reset_n = 1'b0;
      #1;
      chk("arst_d_hsync", d_hsync, 0);
      chk("arst_d_de", d_de, 0);
      chk("arst_d_fc", d_fc, 0);
      chk("arst_d_cx", d_cx, 0);
      chk("arst_d_hblank", d_hblank, 1);
      chk("arst_s_hsync", s_hsync, 1);
      chk("arst_s_vsync", s_vsync, 1);
      chk("arst_s_fc", s_fc, 0);
      chk("arst_s_sof", s_sof, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
Parametrised video timing generator and successor to the fixed 640x480 sync generator. Porches, sync widths, sync polarities and counter width are all set by parameters. Adds a pixel clock-enable, a run enable, a display-enable output, line/frame start strobes and a frame counter. It sits between the system pixel clock and the game renderer / video output stage, which consume the coordinates and the blanking and sync flags.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, horizontal sync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines per frame
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vertical sync width (lines)
V_BP, 33, vertical back porch (lines)
HS_POL, 1, hsync asserted level (1 = active-high, 0 = active-low)
VS_POL, 1, vsync asserted level
CW, 12, width of coordinate counters and outputs
FCW, 8, width of frame counter

Ports:
Clk  in  1  pixel-domain clock
Reset_n  in  1  asynchronous active-low reset
ce  in  1  pixel enable; all state advances only when ce=1
run  in  1  1 = free-running; 0 = hold at origin
hsync  out  1  horizontal sync, polarity HS_POL
vsync  out  1  vertical sync, polarity VS_POL
hblank  out  1  1 when x >= H_ACTIVE
vblank  out  1  1 when y >= V_ACTIVE
de  out  1  ~hblank & ~vblank
counter_x  out  CW  pixel x, aligned with flags
counter_y  out  CW  line y, aligned with flags
sol  out  1  one-ce-tick pulse at x=0
sof  out  1  one-ce-tick pulse at x=0, y=0
frame_cnt  out  FCW  completed-frame count, wraps

Behaviour:
- Single clock, Clk. Reset is asynchronous and active-low, on Reset_n.
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way from the V_* parameters. Elaboration error if H_TOTAL or V_TOTAL >= 2^CW.
- Internal counters hx, vy:
  - On ce=1 and run=1: hx increments. hx wraps to 0 after H_TOTAL-1.
  - On hx wrap, vy increments. vy wraps to 0 after V_TOTAL-1.
  - ce=0: everything holds, including outputs and pulses (pulses stretch across ce=0 cycles).
- run=0 with ce=1: hx and vy are forced to 0 on that tick. The output stage keeps updating, so outputs settle to the origin decode. Releasing run resumes counting from (0,0).
- Output stage: one ce-qualified register stage.
  - All outputs update together on ce=1 from the current hx and vy.
  - Latency is 1 ce tick; counter_x and counter_y are always coherent with the flags.
- Region decode per axis:
  - active: [0, ACTIVE-1]
  - front porch: [ACTIVE, ACTIVE+FP-1]
  - sync: [ACTIVE+FP, ACTIVE+FP+SYNC-1]
  - back porch: remainder up to TOTAL-1.
- hsync = HS_POL while hx is in the horizontal sync region, else ~HS_POL.
- vsync changes only on the tick where hsync transitions to asserted. It takes the vertical-sync decode of vy on that tick and holds between hsync leading edges, so the vsync edge is aligned to the hsync leading edge.
- sol = (hx==0). sof = (hx==0 && vy==0).
- frame_cnt increments by 1 (mod 2^FCW) on the tick where sof is registered to 1. It does not increment while run=0.
- Reset values:
  - counters, counter_x, counter_y, frame_cnt: 0
  - hsync = ~HS_POL, vsync = ~VS_POL
  - hblank = 1, vblank = 1, de = 0
  - sol = 0, sof = 0
- The first ce tick after reset registers the (0,0) decode: de=1, sol=1, sof=1, frame_cnt=1.
- Reset mid-frame: immediate asynchronous return to the reset values. There is no partial-frame completion.
- Simultaneous events: an hx wrap together with a vy wrap in one tick is legal; the next tick decodes (0,0).

Decomposition:
- Shared package vga_timing_pkg holds:
  - per-mode constant sets, with VGA640x480 as default and a 320x240-doubled variant;
  - a region enum: ACTIVE, FP, SYNC, BP;
  - a function computing TOTAL from the four parameters.
- One natural sub-module, vga_axis_counter: parametrised ACTIVE/FP/SYNC/BP and CW, with inputs inc and clr. It outputs the count, wrap, blank and in_sync. It is instantiated twice, once per axis; the horizontal wrap drives the vertical inc.
- The top level holds the output register stage, the vsync edge alignment and frame_cnt.

Test Plan:
- Defaults, ce=1, run=1, after reset release: first frame -> hsync asserted for x=656..751 (96 ticks) each line; line period exactly 800 ticks; frame period exactly 420000 ticks; sof once per frame.
- Defaults: vsync -> asserts only on the hsync leading edge of line y=490 and deasserts on the hsync leading edge of line y=492. Never toggles at any other time.
- ce toggling 1,0,1,0 -> every output is unchanged in ce=0 cycles; line period is 1600 clocks; sol high for 2 consecutive clocks.
- run dropped at (x=300, y=200) for 10 ce ticks, then raised -> outputs show (0,0) with sof=1; frame_cnt increments once on resume; line then counts from 0.
- Reset_n pulsed low mid-line at x=400, asynchronously -> outputs reach the reset values in the same cycle without a clock edge: hsync=~HS_POL, de=0, frame_cnt=0.
- Small-mode parameters (H 8,2,2,2; V 4,1,1,1; HS_POL=0, VS_POL=0) -> H_TOTAL=14, V_TOTAL=7; hsync low for x=10..11; de high for 32 ticks per frame; frame_cnt wraps 255->0 after 256 frames.
